// File: rtl/cpu5_memarb.sv
// cpu5_memarb: unified-memory arbiter for the cpu5 core.
// Shares one external memory port between instruction fetch (if_*) and
// load/store (d_*), breaks ties round-robin, runs the req/ack handshake and
// raises stall while a requester is waiting.
// Optional feature macro: CPU5_MEMARB_TIMEOUT_EN -- aborts a transfer after
// TIMEOUT busy cycles without mem_ack and pulses err alongside the valid.
`ifndef CPU5_XLEN
`define CPU5_XLEN 32
`endif

module cpu5_memarb #(
   parameter int unsigned XLEN    = `CPU5_XLEN,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            if_req,
   input  logic [XLEN-1:0] if_addr,
   output logic [XLEN-1:0] if_rdata,
   output logic            if_valid,
   input  logic            d_req,
   input  logic            d_we,
   input  logic [XLEN-1:0] d_addr,
   input  logic [XLEN-1:0] d_wdata,
   output logic [XLEN-1:0] d_rdata,
   output logic            d_valid,
   output logic            mem_req,
   output logic            mem_we,
   output logic [XLEN-1:0] mem_addr,
   output logic [XLEN-1:0] mem_wdata,
   input  logic            mem_ack,
   input  logic [XLEN-1:0] mem_rdata,
   output logic            stall,
   output logic            err
);

   typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_t;

   localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

   state_t state, state_next;
   logic   last_grant;   // 1 = data port; during a transfer it names the owner
   logic   grant_i, grant_d, done, abort;
   logic   timeout_hit;

`ifdef CPU5_MEMARB_TIMEOUT_EN
   logic [15:0] busy_cnt;

   assign timeout_hit = (busy_cnt == TO_LAST);

   // Count busy cycles without ack; err mirrors the abort into the valid cycle
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         busy_cnt <= '0;
         err      <= 1'b0;
      end else begin
         err <= abort;
         if (grant_i || grant_d)
            busy_cnt <= '0;
         else if ((state == BUSY_I || state == BUSY_D) && !mem_ack)
            busy_cnt <= busy_cnt + 16'd1;
      end
   end
`else
   logic unused_timeout;

   assign timeout_hit    = 1'b0;
   assign unused_timeout = ^TO_LAST;
   assign err            = 1'b0;
`endif

   // Requester is stalled until its own completion pulse
   assign stall = (if_req & ~if_valid) | (d_req & ~d_valid);

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_next;
   end

   // Next-state and grant/completion strobes; ack wins over a same-cycle timeout
   always_comb begin
      state_next = state;
      grant_i    = 1'b0;
      grant_d    = 1'b0;
      done       = 1'b0;
      abort      = 1'b0;
      case (state)
         IDLE: begin
            if (if_req && (!d_req || last_grant)) begin
               grant_i    = 1'b1;
               state_next = BUSY_I;
            end else if (d_req) begin
               grant_d    = 1'b1;
               state_next = BUSY_D;
            end
         end
         BUSY_I, BUSY_D: begin
            if (mem_ack) begin
               done       = 1'b1;
               state_next = RESP;
            end else if (timeout_hit) begin
               abort      = 1'b1;
               state_next = RESP;
            end
         end
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Memory port, read-data capture and one-cycle completion pulses
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         if_rdata   <= '0;
         d_rdata    <= '0;
         if_valid   <= 1'b0;
         d_valid    <= 1'b0;
         last_grant <= 1'b1;
      end else begin
         if_valid <= 1'b0;
         d_valid  <= 1'b0;
         if (grant_i) begin
            mem_req    <= 1'b1;
            mem_we     <= 1'b0;
            mem_addr   <= if_addr;
            mem_wdata  <= '0;
            last_grant <= 1'b0;
         end
         if (grant_d) begin
            mem_req    <= 1'b1;
            mem_we     <= d_we;
            mem_addr   <= d_addr;
            mem_wdata  <= d_wdata;
            last_grant <= 1'b1;
         end
         if (done || abort) begin
            mem_req <= 1'b0;
            if (last_grant) begin
               d_valid <= 1'b1;
               if (!mem_we) d_rdata <= done ? mem_rdata : '0;
            end else begin
               if_valid <= 1'b1;
               if_rdata <= done ? mem_rdata : '0;
            end
         end
      end
   end

endmodule

// File: tb/tb_cpu5_memarb.sv
// Scoreboard bench for cpu5_memarb: stimulus pushes expected memory requests
// and responses; a negedge monitor pops and compares when the DUT presents them.
module tb_cpu5_memarb;

   logic        clk = 1'b0;
   logic        reset;
   logic        if_req, d_req, d_we;
   logic [31:0] if_addr, d_addr, d_wdata;
   logic [31:0] if_rdata, d_rdata;
   logic        if_valid, d_valid;
   logic        mem_req, mem_we, mem_ack;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        stall, err;

   logic        ack_force = 1'b0;
   logic        ack_model = 1'b0;
   bit          ack_en    = 1'b1;
   int          ack_dly   = 0;

   int checks = 0;
   int passes = 0;
   int cyc    = 0;

   typedef struct {
      bit          port;
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      bit          e;
      int          lat;
   } exp_t;

   exp_t exp_mem[$];
   exp_t exp_rsp[$];

   bit [31:0] memory [bit [31:0]];

   cpu5_memarb #(.XLEN(32), .TIMEOUT(4)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_valid(d_valid),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .stall(stall), .err(err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   assign mem_ack = ack_force | ack_model;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act === expv) passes++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
   endtask

   task automatic expect_xfer(input bit port, input bit we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rdata,
                              input bit e, input int lat, input bit rsp);
      exp_t x;
      x.port = port; x.we = we; x.addr = addr; x.wdata = wdata;
      x.rdata = rdata; x.e = e; x.lat = lat;
      exp_mem.push_back(x);
      if (rsp) exp_rsp.push_back(x);
   endtask

   // Drive one request, hold until its valid, drop at the following edge
   task automatic xfer(input bit port, input bit we, input logic [31:0] addr,
                       input logic [31:0] wdata);
      int n;
      if (port) begin d_we = we; d_addr = addr; d_wdata = wdata; d_req = 1'b1; end
      else begin if_addr = addr; if_req = 1'b1; end
      n = 0;
      do begin
         @(posedge clk); #1; n++;
      end while (!(port ? d_valid : if_valid) && n < 100);
      if (!(port ? d_valid : if_valid)) chk("xfer_timeout", port ? d_valid : if_valid, 1);
      @(posedge clk); #1;
      if (port) d_req = 1'b0; else if_req = 1'b0;
   endtask

   // Memory model: acks ack_dly cycles after mem_req is first seen
   initial begin
      int wait_cnt;
      wait_cnt = 0;
      mem_rdata = '0;
      forever begin
         @(posedge clk); #1;
         ack_model = 1'b0;
         if (mem_req && ack_en) begin
            if (wait_cnt == ack_dly) begin
               ack_model = 1'b1;
               if (mem_we) begin
                  memory[mem_addr] = mem_wdata;
                  mem_rdata = '0;
               end else begin
                  mem_rdata = memory[mem_addr];
               end
               wait_cnt = 0;
            end else begin
               wait_cnt++;
            end
         end else begin
            wait_cnt = 0;
         end
      end
   end

   // Monitor: compare memory requests and completions against the scoreboard
   initial begin
      logic mreq_q, vq;
      int   rise_cyc;
      exp_t x;
      mreq_q = 1'b0; vq = 1'b0; rise_cyc = 0;
      forever begin
         @(negedge clk);
         if (mem_req && !mreq_q) begin
            rise_cyc = cyc;
            if (exp_mem.size() == 0) chk("mem_unexpected", mem_req, 0);
            else begin
               x = exp_mem.pop_front();
               chk("mem_we", mem_we, x.we);
               chk("mem_addr", mem_addr, x.addr);
               if (x.we) chk("mem_wdata", mem_wdata, x.wdata);
            end
         end
         mreq_q = mem_req;
         if (if_valid || d_valid) begin
            chk("valid_exclusive", if_valid & d_valid, 0);
            chk("valid_single", vq, 0);
            if (exp_rsp.size() == 0) chk("rsp_unexpected", if_valid | d_valid, 0);
            else begin
               x = exp_rsp.pop_front();
               chk("rsp_port", d_valid, x.port);
               chk("rsp_data", x.port ? d_rdata : if_rdata, x.rdata);
               chk("rsp_err", err, x.e);
               if (x.lat >= 0) chk("rsp_latency", cyc - rise_cyc, x.lat);
            end
         end
         vq = if_valid | d_valid;
      end
   end

   initial begin
      memory[32'h100] = 32'h00500093;
      memory[32'h080] = 32'h11223344;
      memory[32'h200] = 32'h0000000A;
      memory[32'h204] = 32'h0000000B;
      memory[32'h300] = 32'h0000000C;
      memory[32'h304] = 32'h0000000D;
      memory[32'h048] = 32'h55AA55AA;

      // Reset with stale ack and both requests high
      reset = 1'b0; ack_force = 1'b1;
      if_req = 1'b1; if_addr = 32'h100;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80; d_wdata = '0;
      repeat (3) @(negedge clk);
      chk("rst_mem_req", mem_req, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_if_rdata", if_rdata, 0);
      chk("rst_d_rdata", d_rdata, 0);
      chk("rst_if_valid", if_valid, 0);
      chk("rst_d_valid", d_valid, 0);
      chk("rst_err", err, 0);
      ack_force = 1'b0; reset = 1'b1;
      expect_xfer(0, 0, 32'h100, 0, 32'h00500093, 0, 1, 1);
      expect_xfer(1, 0, 32'h080, 0, 32'h11223344, 0, 1, 1);
      fork
         xfer(0, 0, 32'h100, 0);
         xfer(1, 0, 32'h080, 0);
      join

      // Single fetch with 3-cycle memory wait; stall until valid
      @(negedge clk);
      ack_dly = 3;
      expect_xfer(0, 0, 32'h100, 0, 32'h00500093, 0, 4, 1);
      fork
         xfer(0, 0, 32'h100, 0);
         begin
            #1;
            for (int i = 0; i < 20; i++) begin
               if (if_valid) begin
                  chk("stall_at_valid", stall, 0);
                  break;
               end
               chk("stall_waiting", stall, 1);
               @(negedge clk);
            end
         end
      join

      // Store then load to the same address
      @(negedge clk);
      ack_dly = 0;
      expect_xfer(1, 1, 32'h40, 32'hDEADBEEF, 32'h11223344, 0, 1, 1);
      expect_xfer(1, 0, 32'h40, 0, 32'hDEADBEEF, 0, 1, 1);
      xfer(1, 1, 32'h40, 32'hDEADBEEF);
      xfer(1, 0, 32'h40, 0);

      // Contention: grants alternate I, D, I, D
      @(negedge clk);
      expect_xfer(0, 0, 32'h200, 0, 32'h0A, 0, 1, 1);
      expect_xfer(1, 0, 32'h300, 0, 32'h0C, 0, 1, 1);
      expect_xfer(0, 0, 32'h204, 0, 32'h0B, 0, 1, 1);
      expect_xfer(1, 0, 32'h304, 0, 32'h0D, 0, 1, 1);
      fork
         begin xfer(0, 0, 32'h200, 0); xfer(0, 0, 32'h204, 0); end
         begin xfer(1, 0, 32'h300, 0); xfer(1, 0, 32'h304, 0); end
      join

      // Reset mid-transfer, then a stale ack after release
      @(negedge clk);
      ack_en = 0;
      expect_xfer(1, 0, 32'h40, 0, 0, 0, 0, 0);
      d_we = 1'b0; d_addr = 32'h40; d_req = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("busy_mem_req", mem_req, 1);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("async_mem_req", mem_req, 0);
      chk("async_mem_addr", mem_addr, 0);
      d_req = 1'b0; ack_force = 1'b1;
      @(negedge clk);
      reset = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("stale_d_valid", d_valid, 0);
         chk("stale_mem_req", mem_req, 0);
      end
      ack_force = 1'b0; ack_en = 1;

      // No ack from memory
      @(negedge clk);
      ack_en = 0;
`ifdef CPU5_MEMARB_TIMEOUT_EN
      expect_xfer(1, 0, 32'h48, 0, 32'h0, 1, 4, 1);
      xfer(1, 0, 32'h48, 0);
      ack_en = 1;
`else
      expect_xfer(1, 0, 32'h48, 0, 32'h55AA55AA, 0, -1, 1);
      fork
         xfer(1, 0, 32'h48, 0);
         begin
            repeat (10) @(negedge clk);
            chk("noack_mem_req", mem_req, 1);
            chk("noack_err", err, 0);
            chk("noack_d_valid", d_valid, 0);
            ack_en = 1;
         end
      join
`endif

      repeat (4) @(negedge clk);
      chk("exp_mem_left", exp_mem.size(), 0);
      chk("exp_rsp_left", exp_rsp.size(), 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/cpu5_memarb.md
# cpu5_memarb

Unified-memory arbiter and sequencer for the cpu5 core. It shares a single external memory port between the instruction-fetch path (PC/instr) and the load/store path (dataaddr/writedata/readdata) of the datapath. It serialises requests with round-robin tie-breaking, runs the req/ack handshake toward memory, and raises `stall` so the control unit can freeze the PC register while a transfer is outstanding.

## Interface
Parameters:
- `XLEN`, default `CPU5_XLEN` (32): address/data width.
- `TIMEOUT`, default 255: number of cycles in a busy state without `mem_ack` before abort. Legal range 1..65535. Used only with the timeout macro.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low (0 = reset). Clears all state immediately.
- `if_req` in 1: fetch request. Held high, with `if_addr` stable, until `if_valid`.
- `if_addr` in XLEN: fetch address (PC).
- `if_rdata` out XLEN: fetched instruction. Registered; valid while `if_valid`=1.
- `if_valid` out 1: one-cycle completion pulse for fetch.
- `d_req` in 1: load/store request. Held high, with `d_we`, `d_addr` and `d_wdata` stable, until `d_valid`.
- `d_we` in 1: 1 = store, 0 = load.
- `d_addr` in XLEN: data address (ALU output).
- `d_wdata` in XLEN: store data (rs2).
- `d_rdata` out XLEN: load data. Registered.
- `d_valid` out 1: one-cycle completion pulse for data.
- `mem_req`, `mem_we` out 1: memory request and write enable. Registered.
- `mem_addr`, `mem_wdata` out XLEN: memory address and write data. Registered.
- `mem_ack` in 1: memory completion, one cycle. Sampled only while `mem_req`=1.
- `mem_rdata` in XLEN: read data, valid with `mem_ack`.
- `stall` out 1: combinational; `(if_req & ~if_valid) | (d_req & ~d_valid)`.
- `err` out 1: timeout pulse. Tied 0 without the macro.

## Operation
- States: IDLE, BUSY_I, BUSY_D, RESP. Reset state is IDLE.
- IDLE:
  - Only `if_req` → BUSY_I. Only `d_req` → BUSY_D.
  - Both → grant the port that was not granted last. The `last_grant` register resets to D, so fetch wins the first tie.
  - On grant: load `mem_addr`/`mem_we`/`mem_wdata` from the granted port; set `mem_req`=1; update `last_grant`. Fetch grants force `mem_we`=0.
- BUSY_x: hold `mem_*` stable. On `mem_ack`:
  - Clear `mem_req`.
  - If the transfer is a read, capture `mem_rdata` into `if_rdata` or `d_rdata`. Stores leave `d_rdata` unchanged.
  - Go to RESP.
- RESP: pulse the granted port's valid for exactly one cycle. Both requests are ignored in this cycle, so the requester drops req at the following edge. Next state is always IDLE.
- `mem_ack` in IDLE or RESP is ignored, including a stale ack arriving after reset.
- Reset values: `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `if_rdata`=0, `d_rdata`=0, `if_valid`=0, `d_valid`=0, `err`=0, `last_grant`=D.
- Reset asserted mid-transfer: the FSM returns to IDLE and `mem_req` drops asynchronously. The requester must re-issue its request.

## Timing
- Request first seen high in IDLE at edge N → `mem_req`=1 from N+1.
- `mem_ack` may arrive in the first `mem_req` cycle or any later one. If ack is sampled at edge M, valid is high during cycle M..M+1 (RESP) and the FSM is in IDLE after edge M+1.
- Minimum request-to-valid latency: 2 cycles. Minimum spacing between memory requests: 3 cycles.
- With both ports requesting continuously, grants strictly alternate: I, D, I, D …
- `stall` falls in the same cycle valid rises.

## Configuration
- `CPU5_MEMARB_TIMEOUT_EN` defined:
  - A 16-bit counter clears on grant and increments each BUSY cycle without ack.
  - When the count reaches `TIMEOUT`: `mem_req` drops, the FSM enters RESP, and the granted valid pulses with rdata forced to 0 (`d_rdata` unchanged for stores).
  - `err` pulses high in the same cycle as that valid.
  - An ack in the same cycle the count reaches `TIMEOUT` wins; no error is reported.
- Not defined: no counter; BUSY waits indefinitely; `err` is constant 0.

## Test plan
- Reset: hold `reset`=0 with `mem_ack`=1 and both reqs high → all outputs at reset values, no valid pulses. Release reset → fetch is granted first.
- Single fetch: `if_addr`=0x100, memory acks 3 cycles after `mem_req`, `mem_rdata`=0x00500093 → `if_rdata`=0x00500093, `if_valid` high for one cycle; `stall` high from the request cycle until valid.
- Store then load: store of 0xDEADBEEF to 0x40, then load from 0x40 → first transfer has `mem_we`=1 with `mem_wdata`=0xDEADBEEF and `d_rdata` unchanged; the load returns 0xDEADBEEF.
- Contention: `if_req` and `d_req` held high for 4 transfers → grant order I, D, I, D; each valid is a single cycle; zero-wait ack gives valid 2 cycles after grant.
- Reset mid-transfer: assert reset in BUSY_D, then present a stale ack after release → `mem_req` drops immediately; the stale ack produces no `d_valid`.
- With the macro and `TIMEOUT`=4, no ack → `mem_req` drops after 4 busy cycles; `d_valid`=1, `err`=1 and `d_rdata`=0 in the same cycle. Without the macro → `mem_req` stays high and `err` stays 0.
